// File: rtl/quad_pkg.sv
// Shared types for the quadrature sampling controller.
package quad_pkg;

    localparam int QUAD_CNT_W = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEEK = 2'd2
    } state_t;

    typedef struct packed {
        logic [QUAD_CNT_W-1:0] pos;
        logic [QUAD_CNT_W-1:0] vel;
        logic                  homed;
    } sample_t;

endpackage

// File: rtl/quad_sample_fifo.sv
// Two-entry sample buffer; a push while full with no pop is dropped and flagged.
module quad_sample_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop_req,
    output logic [DW-1:0] dout,
    output logic [1:0]    count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [DW-1:0] mem_q [2];
    logic [DW-1:0] mem_d [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;
    logic          wr_en;

    // Occupancy, pointer and storage update; a full buffer still accepts when popped the same cycle.
    always_comb begin
        empty = (cnt_q == 2'd0);
        full  = (cnt_q == 2'd2);
        pop   = pop_req & ~empty;
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (wr_en) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        dout  = mem_q[rd_q];
        count = cnt_q;
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (nrst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quad_sample_ctrl.sv
// Homing and periodic position/velocity sampling for the quadrature counter.
module quad_sample_ctrl
    import quad_pkg::*;
#(
    parameter int CNT_W = QUAD_CNT_W,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [CNT_W-1:0] count,
    input  logic             index,
    input  logic             enable,
    input  logic             home_req,
    input  logic [DIV_W-1:0] period,
    input  logic             ovr_clr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_pos,
    output logic [CNT_W-1:0] m_vel,
    output logic             m_homed,
    output logic             homed,
    output logic             seeking,
    output logic             overrun
);

    localparam int SMP_W = 2 * CNT_W + 1;

    state_t           state_q, state_d;
    logic             idx_s1_q, idx_s2_q, idx_dly_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] offset_q, offset_d;
    logic [CNT_W-1:0] prev_pos_q, prev_pos_d;
    logic             homed_q, homed_d;
    logic             first_q, first_d;
    logic             overrun_q, overrun_d;
    logic             tick;
    logic             capture;
    logic [CNT_W-1:0] pos, vel;
    logic [SMP_W-1:0] smp_in, smp_out;
    logic             fifo_empty;
    logic             fifo_drop;

    // Index synchronizer plus one delay flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (nrst) begin
            idx_s1_q  <= 1'b0;
            idx_s2_q  <= 1'b0;
            idx_dly_q <= 1'b0;
        end else begin
            idx_s1_q  <= index;
            idx_s2_q  <= idx_s1_q;
            idx_dly_q <= idx_s2_q;
        end
    end

    // Next state; dropping enable wins from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (home_req) state_d = SEEK;
            SEEK:    if (capture) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
        end
    end

    // Divider, sample arithmetic, homing and overrun bookkeeping.
    always_comb begin
        capture = (state_q == SEEK) & idx_s2_q & ~idx_dly_q;
        tick    = (state_q != IDLE) && (div_q == '0);
        pos     = count - offset_q;
        vel     = first_q ? '0 : pos - prev_pos_q;
        smp_in  = {pos, vel, homed_q};

        div_d = div_q - 1'b1;
        if (state_q == IDLE || tick) begin
            div_d = period;
        end

        offset_d   = capture ? count : offset_q;
        homed_d    = homed_q | capture;
        prev_pos_d = tick ? pos : prev_pos_q;

        // A capture coinciding with a tick re-arms first so the following sample starts clean.
        first_d = first_q;
        if (tick) begin
            first_d = 1'b0;
        end
        if (capture || state_q == IDLE) begin
            first_d = 1'b1;
        end

        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (fifo_drop) begin
            overrun_d = 1'b1;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            offset_q   <= '0;
            prev_pos_q <= '0;
            homed_q    <= 1'b0;
            first_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            offset_q   <= offset_d;
            prev_pos_q <= prev_pos_d;
            homed_q    <= homed_d;
            first_q    <= first_d;
            overrun_q  <= overrun_d;
        end
    end

    quad_sample_fifo #(
        .DW (SMP_W)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push    (tick),
        .din     (smp_in),
        .pop_req (m_ready),
        .dout    (smp_out),
        .count   (),
        .full    (),
        .empty   (fifo_empty),
        .drop    (fifo_drop)
    );

    // Output unpacking and status flags.
    always_comb begin
        m_valid                  = ~fifo_empty;
        {m_pos, m_vel, m_homed}  = smp_out;
        homed                    = homed_q;
        seeking                  = (state_q == SEEK);
        overrun                  = overrun_q;
    end

endmodule

// File: tb/tb_quad_sample_ctrl.sv
// Directed bench for quad_sample_ctrl: vector table plus multi-cycle sequences.
module tb_quad_sample_ctrl;
    import quad_pkg::*;

    localparam int CW = 22;

    logic          clk = 1'b0;
    logic          nrst, index, enable, home_req, ovr_clr, m_ready;
    logic [CW-1:0] count;
    logic [15:0]   period;
    logic          m_valid, m_homed, homed, seeking, overrun;
    logic [CW-1:0] m_pos, m_vel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          rst;
        logic          en;
        logic          rdy;
        logic [CW-1:0] cnt;
        logic [15:0]   per;
        logic          e_valid;
        logic [CW-1:0] e_pos;
        logic [CW-1:0] e_vel;
    } vec_t;

    vec_t tbl[$];
    vec_t r;

    always #5 clk = ~clk;

    quad_sample_ctrl #(
        .CNT_W (22),
        .DIV_W (16)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .count    (count),
        .index    (index),
        .enable   (enable),
        .home_req (home_req),
        .period   (period),
        .ovr_clr  (ovr_clr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_pos    (m_pos),
        .m_vel    (m_vel),
        .m_homed  (m_homed),
        .homed    (homed),
        .seeking  (seeking),
        .overrun  (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_smp(input string n, input logic ev, input logic [CW-1:0] ep,
                           input logic [CW-1:0] evl, input logic eh);
        chk({n, "_valid"}, {31'd0, m_valid}, {31'd0, ev});
        if (ev) begin
            chk({n, "_pos"}, {10'd0, m_pos}, {10'd0, ep});
            chk({n, "_vel"}, {10'd0, m_vel}, {10'd0, evl});
            chk({n, "_mhomed"}, {31'd0, m_homed}, {31'd0, eh});
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b1; enable = 1'b0; home_req = 1'b0; index = 1'b0;
        ovr_clr = 1'b0; m_ready = 1'b0; period = '0; count = '0;
        cyc();
        cyc();
        nrst = 1'b0;
    endtask

    function automatic void add(input logic rst, input logic en, input logic rdy,
                                input logic [CW-1:0] cnt, input logic [15:0] per,
                                input logic ev, input logic [CW-1:0] ep, input logic [CW-1:0] evl);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.cnt = cnt; v.per = per;
        v.e_valid = ev; v.e_pos = ep; v.e_vel = evl;
        tbl.push_back(v);
    endfunction

    initial begin
        // Basic ramp, period 3: samples on rows 5, 9, 13, 17; row 18 holds the last one.
        add(1'b1, 1'b0, 1'b0, '0, 16'd0, 1'b0, '0, '0);
        add(1'b1, 1'b0, 1'b0, '0, 16'd0, 1'b0, '0, '0);
        for (int k = 1; k <= 18; k++) begin
            add(1'b0, 1'b1, (k != 18), 22'(32'h20 + k), 16'd3,
                ((k >= 5) && (k % 4 == 1)) || (k == 18),
                (k == 18) ? 22'h31 : 22'(32'h20 + k),
                (k == 5) ? 22'd0 : 22'd4);
        end
        // Reset with a held sample flushes the buffer.
        add(1'b1, 1'b0, 1'b0, '0, 16'd0, 1'b0, '0, '0);
        // Modular wrap of the count between two samples.
        for (int k = 1; k <= 4; k++) add(1'b0, 1'b1, 1'b1, 22'h3FFFFE, 16'd3, 1'b0, '0, '0);
        add(1'b0, 1'b1, 1'b1, 22'h3FFFFE, 16'd3, 1'b1, 22'h3FFFFE, 22'd0);
        for (int k = 6; k <= 8; k++) add(1'b0, 1'b1, 1'b1, 22'h000002, 16'd3, 1'b0, '0, '0);
        add(1'b0, 1'b1, 1'b1, 22'h000002, 16'd3, 1'b1, 22'h000002, 22'h000004);
        add(1'b0, 1'b1, 1'b1, 22'h000002, 16'd3, 1'b0, '0, '0);

        index = 1'b0; home_req = 1'b0; ovr_clr = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            nrst = r.rst; enable = r.en; m_ready = r.rdy; count = r.cnt; period = r.per;
            cyc();
            chk($sformatf("row%0d_valid", i), {31'd0, m_valid}, {31'd0, r.e_valid});
            if (r.e_valid || r.rst) begin
                chk($sformatf("row%0d_pos", i), {10'd0, m_pos}, {10'd0, r.e_pos});
                chk($sformatf("row%0d_vel", i), {10'd0, m_vel}, {10'd0, r.e_vel});
            end
            chk($sformatf("row%0d_homed", i), {31'd0, homed}, 32'd0);
            chk($sformatf("row%0d_seeking", i), {31'd0, seeking}, 32'd0);
            chk($sformatf("row%0d_overrun", i), {31'd0, overrun}, 32'd0);
        end

        // Homing, then enable drop during a second seek, drain and re-enable.
        do_reset();
        enable = 1'b1; period = 16'd7; m_ready = 1'b1; count = 22'h100;
        cyc();
        home_req = 1'b1; cyc();
        home_req = 1'b0;
        chk("seek_enter", {31'd0, seeking}, 32'd1);
        chk("homed_pre", {31'd0, homed}, 32'd0);
        index = 1'b1; cyc();
        index = 1'b0; cyc();
        chk("homed_e4", {31'd0, homed}, 32'd0);
        chk("seek_e4", {31'd0, seeking}, 32'd1);
        cyc();
        chk("homed_e5", {31'd0, homed}, 32'd1);
        chk("seek_e5", {31'd0, seeking}, 32'd0);
        count = 22'h150;
        repeat (3) cyc();
        chk("no_smp_e8", {31'd0, m_valid}, 32'd0);
        cyc();
        chk_smp("home_smp1", 1'b1, 22'h50, 22'd0, 1'b1);
        cyc();
        chk("home_pop", {31'd0, m_valid}, 32'd0);
        count = 22'h158;
        repeat (7) cyc();
        chk_smp("home_smp2", 1'b1, 22'h58, 22'h8, 1'b1);
        home_req = 1'b1; m_ready = 1'b0; cyc();
        home_req = 1'b0; count = 22'h160;
        chk("seek2", {31'd0, seeking}, 32'd1);
        repeat (7) cyc();
        chk("seek2_hold", {31'd0, seeking}, 32'd1);
        chk_smp("buf_head", 1'b1, 22'h58, 22'h8, 1'b1);
        enable = 1'b0; cyc();
        chk("abort_idle", {31'd0, seeking}, 32'd0);
        chk("abort_homed", {31'd0, homed}, 32'd1);
        chk_smp("drain0", 1'b1, 22'h58, 22'h8, 1'b1);
        m_ready = 1'b1; home_req = 1'b1; cyc();
        home_req = 1'b0;
        chk("idle_ignore_home", {31'd0, seeking}, 32'd0);
        chk_smp("drain1", 1'b1, 22'h60, 22'h8, 1'b1);
        cyc();
        chk("drained", {31'd0, m_valid}, 32'd0);
        chk("idle_stay", {31'd0, seeking}, 32'd0);
        enable = 1'b1; count = 22'h170; cyc();
        repeat (7) cyc();
        chk("reen_wait", {31'd0, m_valid}, 32'd0);
        cyc();
        chk_smp("reen_vel0", 1'b1, 22'h70, 22'd0, 1'b1);

        // Overrun, clear-vs-set priority, push+pop while full.
        do_reset();
        enable = 1'b1; period = 16'd0; m_ready = 1'b0; count = 22'h11; cyc();
        count = 22'h12; cyc();
        chk_smp("ov_s0", 1'b1, 22'h12, 22'd0, 1'b0);
        chk("ov_none0", {31'd0, overrun}, 32'd0);
        count = 22'h13; cyc();
        chk_smp("ov_hold", 1'b1, 22'h12, 22'd0, 1'b0);
        chk("ov_none1", {31'd0, overrun}, 32'd0);
        count = 22'h14; cyc();
        chk("ov_set", {31'd0, overrun}, 32'd1);
        chk_smp("ov_keep", 1'b1, 22'h12, 22'd0, 1'b0);
        count = 22'h15; ovr_clr = 1'b1; cyc();
        ovr_clr = 1'b0;
        chk("ov_set_wins", {31'd0, overrun}, 32'd1);
        count = 22'h16; enable = 1'b0; cyc();
        chk("ov_sticky", {31'd0, overrun}, 32'd1);
        count = 22'h17; ovr_clr = 1'b1; cyc();
        ovr_clr = 1'b0;
        chk("ov_clr", {31'd0, overrun}, 32'd0);
        chk_smp("ov_keep2", 1'b1, 22'h12, 22'd0, 1'b0);
        count = 22'h18; m_ready = 1'b1; cyc();
        chk_smp("ov_pop", 1'b1, 22'h13, 22'd1, 1'b0);
        enable = 1'b1; m_ready = 1'b0; count = 22'h19; cyc();
        count = 22'h1A; cyc();
        chk_smp("ov_refill", 1'b1, 22'h13, 22'd1, 1'b0);
        count = 22'h1B; m_ready = 1'b1; cyc();
        chk("pushpop_no_ov", {31'd0, overrun}, 32'd0);
        chk_smp("pushpop_head", 1'b1, 22'h1A, 22'd0, 1'b0);
        count = 22'h1C; enable = 1'b0; cyc();
        chk("pushpop2_no_ov", {31'd0, overrun}, 32'd0);
        chk_smp("pp2_head", 1'b1, 22'h1B, 22'd1, 1'b0);
        cyc();
        chk_smp("pp_tail", 1'b1, 22'h1C, 22'd1, 1'b0);
        cyc();
        chk("pp_empty", {31'd0, m_valid}, 32'd0);

        // Tick and index capture in the same cycle.
        do_reset();
        enable = 1'b1; period = 16'd3; m_ready = 1'b1; count = 22'h200; cyc();
        home_req = 1'b1; cyc();
        home_req = 1'b0;
        repeat (3) cyc();
        chk_smp("tc_s0", 1'b1, 22'h200, 22'd0, 1'b0);
        chk("tc_seek", {31'd0, seeking}, 32'd1);
        count = 22'h210; cyc();
        index = 1'b1; cyc();
        index = 1'b0; cyc();
        chk("tc_pre", {31'd0, homed}, 32'd0);
        cyc();
        chk_smp("tc_old_off", 1'b1, 22'h210, 22'h10, 1'b0);
        chk("tc_homed", {31'd0, homed}, 32'd1);
        chk("tc_seek_end", {31'd0, seeking}, 32'd0);
        count = 22'h215;
        repeat (4) cyc();
        chk_smp("tc_new_off", 1'b1, 22'h5, 22'd0, 1'b1);
        count = 22'h21C;
        repeat (4) cyc();
        chk_smp("tc_after", 1'b1, 22'hC, 22'h7, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
